// File: rtl/htc_attractor_search.sv
// Nearest-attractor search: streams attractor rows out of the HTC BRAM and
// returns the lowest-index row with the minimum Hamming distance to a query.
module htc_attractor_search #(
    parameter int D        = 173,
    parameter int D_PADDED = 192,
    parameter int R        = 2048,
    parameter int IW       = $clog2(R),
    parameter int DW       = $clog2(D + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                query_valid,
    output logic                query_ready,
    input  logic [D-1:0]        query_hv,
    input  logic [IW:0]         active_rows,
    input  logic                loader_busy,
    output logic                bram_re,
    output logic [IW-1:0]       bram_raddr,
    input  logic [D_PADDED-1:0] bram_rdata,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [IW-1:0]       result_idx,
    output logic [DW-1:0]       result_dist,
    output logic                result_empty,
    output logic                result_stale,
    output logic                busy,
    output logic [31:0]         search_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESULT} state_t;

    state_t          state_reg, state_next;
    logic            rst_done_reg;
    logic [D-1:0]    query_reg;
    logic [IW:0]     n_reg;
    logic [IW-1:0]   addr_reg;
    logic            rd_valid_reg;
    logic [IW-1:0]   rd_idx_reg;
    logic            dist_valid_reg;
    logic [IW-1:0]   dist_idx_reg;
    logic [DW-1:0]   dist_reg;
    logic [IW-1:0]   best_idx_reg;
    logic [DW-1:0]   best_dist_reg;
    logic            empty_reg;
    logic            stale_reg;
    logic [31:0]     search_count_reg;

    logic            handshake;
    logic [IW:0]     n_clamped;
    logic            last_addr;
    logic            last_cmp;
    logic [D-1:0]    diff;
    logic [DW-1:0]   pop_next;
    logic            unused_pad;

    assign handshake = query_valid && query_ready;
    assign n_clamped = (active_rows > (IW+1)'(R)) ? (IW+1)'(R) : active_rows;
    assign last_addr = ({1'b0, addr_reg} == n_reg - 1'b1);
    assign last_cmp  = dist_valid_reg && ({1'b0, dist_idx_reg} == n_reg - 1'b1);
    assign unused_pad = ^bram_rdata[D_PADDED-1:D];

    // Only the live HV bits take part in the distance; padding never reaches the adder.
    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_diff
            assign diff[gi] = query_reg[gi] ^ bram_rdata[gi];
        end
    endgenerate

    always_comb begin
        pop_next = '0;
        for (int i = 0; i < D; i++) begin
            pop_next = pop_next + DW'(diff[i]);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (handshake) state_next = (n_clamped == '0) ? RESULT : SCAN;
            SCAN:    if (last_addr) state_next = DRAIN;
            DRAIN:   if (last_cmp) state_next = RESULT;
            RESULT:  if (result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            rst_done_reg     <= 1'b0;
            query_reg        <= '0;
            n_reg            <= '0;
            addr_reg         <= '0;
            rd_valid_reg     <= 1'b0;
            rd_idx_reg       <= '0;
            dist_valid_reg   <= 1'b0;
            dist_idx_reg     <= '0;
            dist_reg         <= '0;
            best_idx_reg     <= '0;
            best_dist_reg    <= '0;
            empty_reg        <= 1'b0;
            stale_reg        <= 1'b0;
            search_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rst_done_reg <= 1'b1;
            if (handshake) begin
                query_reg <= query_hv;
                n_reg     <= n_clamped;
                addr_reg  <= '0;
                stale_reg <= 1'b0;
                empty_reg <= (n_clamped == '0);
                if (n_clamped == '0) begin
                    best_idx_reg  <= '0;
                    best_dist_reg <= DW'(D);
                end
            end
            if (state_reg == SCAN) addr_reg <= addr_reg + 1'b1;
            // Three-stage pipe: address -> read data -> registered distance -> compare.
            rd_valid_reg   <= bram_re;
            rd_idx_reg     <= addr_reg;
            dist_valid_reg <= rd_valid_reg;
            dist_idx_reg   <= rd_idx_reg;
            dist_reg       <= pop_next;
            if (dist_valid_reg && (dist_idx_reg == '0 || dist_reg < best_dist_reg)) begin
                best_idx_reg  <= dist_idx_reg;
                best_dist_reg <= dist_reg;
            end
            if ((state_reg == SCAN || state_reg == DRAIN) && loader_busy) stale_reg <= 1'b1;
            if (state_reg == RESULT && result_ready) search_count_reg <= search_count_reg + 32'd1;
        end
    end

    assign query_ready  = rst_done_reg && (state_reg == IDLE) && !loader_busy;
    assign bram_re      = (state_reg == SCAN);
    assign bram_raddr   = addr_reg;
    assign result_valid = (state_reg == RESULT);
    assign result_idx   = best_idx_reg;
    assign result_dist  = best_dist_reg;
    assign result_empty = empty_reg;
    assign result_stale = stale_reg;
    assign busy         = (state_reg != IDLE);
    assign search_count = search_count_reg;

endmodule

// File: tb/tb_htc_attractor_search.sv
// Randomized bench for htc_attractor_search against a min-distance reference model.
module tb_htc_attractor_search;
    localparam int D  = 173;
    localparam int DP = 192;
    localparam int R  = 2048;
    localparam int IW = 11;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          query_valid = 1'b0;
    logic          query_ready;
    logic [D-1:0]  query_hv = '0;
    logic [IW:0]   active_rows = '0;
    logic          loader_busy = 1'b0;
    logic          bram_re;
    logic [IW-1:0] bram_raddr;
    logic [DP-1:0] bram_rdata = '0;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [IW-1:0] result_idx;
    logic [DW-1:0] result_dist;
    logic          result_empty;
    logic          result_stale;
    logic          busy;
    logic [31:0]   search_count;

    htc_attractor_search dut (
        .clk(clk), .rst_n(rst_n),
        .query_valid(query_valid), .query_ready(query_ready),
        .query_hv(query_hv), .active_rows(active_rows),
        .loader_busy(loader_busy),
        .bram_re(bram_re), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_idx(result_idx), .result_dist(result_dist),
        .result_empty(result_empty), .result_stale(result_stale),
        .busy(busy), .search_count(search_count)
    );

    always #5 clk = ~clk;

    logic [DP-1:0] mem [R];
    always @(posedge clk) if (bram_re) bram_rdata <= mem[bram_raddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-port monitor: counts reads since the last handshake and checks ordering.
    int rd_count = 0, rd_err = 0, rd_first = -1, rd_last = -1;
    always @(negedge clk) begin
        if (query_valid && query_ready) begin
            rd_count = 0; rd_err = 0; rd_first = -1; rd_last = -1;
        end else if (bram_re) begin
            if (bram_raddr != rd_count[IW-1:0]) rd_err++;
            if (rd_count == 0) rd_first = cyc;
            rd_last = cyc;
            rd_count++;
        end
    end

    int total = 0, bad = 0, exp_sc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [DP-1:0] rand_row();
        logic [DP-1:0] r;
        for (int w = 0; w < DP / 32; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [D-1:0] rand_hv();
        logic [DP-1:0] r;
        r = rand_row();
        return r[D-1:0];
    endfunction

    task automatic run_query(input logic [D-1:0] q, input int n, input int hold,
                             input int stale_at, input string name);
        int n_eff, exp_idx, exp_dist, exp_lat, lat, waited, hs, d;
        logic [D-1:0] x;
        n_eff = (n > R) ? R : n;
        exp_idx = 0;
        exp_dist = D;
        if (n_eff > 0) begin
            exp_dist = D + 1;
            for (int k = 0; k < n_eff; k++) begin
                x = q ^ mem[k][D-1:0];
                d = $countones(x);
                if (d < exp_dist) exp_dist = d;
            end
            exp_idx = -1;
            for (int k = 0; k < n_eff && exp_idx < 0; k++) begin
                x = q ^ mem[k][D-1:0];
                if ($countones(x) == exp_dist) exp_idx = k;
            end
        end
        exp_lat = (n_eff == 0) ? 1 : n_eff + 3;

        waited = 0;
        while (!query_ready && waited < 100) begin
            @(posedge clk); #1; waited++;
        end
        check({name, "_ready_wait"}, waited < 100, 1);
        query_hv = q;
        active_rows = n[IW:0];
        query_valid = 1'b1;
        @(posedge clk); #1;
        query_valid = 1'b0;
        hs = cyc;

        lat = 1;
        while (!result_valid && lat < R + 50) begin
            loader_busy = (lat == stale_at);
            @(posedge clk); #1;
            lat++;
        end
        loader_busy = 1'b0;
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_valid"}, result_valid, 1);
        check({name, "_idx"}, result_idx, exp_idx);
        check({name, "_dist"}, result_dist, exp_dist);
        check({name, "_empty"}, result_empty, n_eff == 0);
        check({name, "_stale"}, result_stale, stale_at > 0);
        check({name, "_rd_count"}, rd_count, n_eff);
        check({name, "_rd_order"}, rd_err, 0);
        if (n_eff > 0) begin
            check({name, "_rd_first"}, rd_first, hs);
            check({name, "_rd_last"}, rd_last, hs + n_eff - 1);
        end
        $display("query %s: n=%0d idx=%0d dist=%0d empty=%0d stale=%0d latency=%0d",
                 name, n, result_idx, result_dist, result_empty, result_stale, lat);

        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            check({name, "_hold_valid"}, result_valid, 1);
            check({name, "_hold_idx"}, result_idx, exp_idx);
            check({name, "_hold_dist"}, result_dist, exp_dist);
            check({name, "_hold_qready"}, query_ready, 0);
            check({name, "_hold_count"}, search_count, exp_sc);
        end

        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        exp_sc++;
        check({name, "_count"}, search_count, exp_sc);
        check({name, "_after_valid"}, result_valid, 0);
        check({name, "_after_qready"}, query_ready, 1);
    endtask

    initial begin
        logic [D-1:0]  q, m;
        logic [DP-1:0] r;
        int rv_seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_qready", query_ready, 0);
        check("rst_bram_re", bram_re, 0);
        check("rst_raddr", bram_raddr, 0);
        check("rst_valid", result_valid, 0);
        check("rst_idx", result_idx, 0);
        check("rst_dist", result_dist, 0);
        check("rst_empty", result_empty, 0);
        check("rst_stale", result_stale, 0);
        check("rst_busy", busy, 0);
        check("rst_count", search_count, 0);
        rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        check("idle_busy", busy, 0);
        check("idle_qready", query_ready, 1);

        // Exact match at row 5, everything else complemented.
        q = rand_hv();
        for (int k = 0; k < 16; k++) begin
            r = rand_row(); r[D-1:0] = ~q; mem[k] = r;
        end
        r = rand_row(); r[D-1:0] = q; mem[5] = r;
        run_query(q, 16, 0, 0, "exact");

        // Tie between rows 3 and 9 at distance 4.
        q = rand_hv();
        for (int k = 0; k < 12; k++) begin
            r = rand_row(); r[D-1:0] = ~q; mem[k] = r;
        end
        m = '0; m[0] = 1'b1; m[50] = 1'b1; m[100] = 1'b1; m[172] = 1'b1;
        r = rand_row(); r[D-1:0] = q ^ m; mem[3] = r;
        m = '0; m[1] = 1'b1; m[60] = 1'b1; m[120] = 1'b1; m[171] = 1'b1;
        r = rand_row(); r[D-1:0] = q ^ m; mem[9] = r;
        run_query(q, 12, 0, 0, "tie");

        // Full scan with all-ones padding; only the last row is close.
        q = rand_hv();
        for (int k = 0; k < R; k++) mem[k] = {{(DP-D){1'b1}}, ~q};
        m = '0; m[7] = 1'b1;
        mem[R-1] = {{(DP-D){1'b1}}, q ^ m};
        run_query(q, R, 0, 0, "full");
        run_query(q, 4095, 0, 0, "clamp");

        run_query(rand_hv(), 0, 0, 0, "empty");

        loader_busy = 1'b1; #1;
        check("loader_idle_qready", query_ready, 0);
        loader_busy = 1'b0; #1;
        check("loader_clear_qready", query_ready, 1);

        q = rand_hv();
        for (int k = 0; k < 20; k++) mem[k] = rand_row();
        run_query(q, 20, 0, 5, "stale");

        q = rand_hv();
        for (int k = 0; k < 10; k++) mem[k] = rand_row();
        run_query(q, 10, 20, 0, "backpressure");

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 40);
            q = rand_hv();
            for (int k = 0; k < n; k++) mem[k] = rand_row();
            run_query(q, n, $urandom_range(0, 3), 0, $sformatf("rand%0d", t));
        end

        // Reset in the middle of a scan must discard the search.
        query_hv = rand_hv();
        active_rows = 12'd100;
        query_valid = 1'b1;
        @(posedge clk); #1;
        query_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("midscan_busy", busy, 1);
        rst_n = 1'b0; #1;
        exp_sc = 0;
        check("midrst_busy", busy, 0);
        check("midrst_bram_re", bram_re, 0);
        check("midrst_raddr", bram_raddr, 0);
        check("midrst_valid", result_valid, 0);
        check("midrst_idx", result_idx, 0);
        check("midrst_dist", result_dist, 0);
        check("midrst_qready", query_ready, 0);
        check("midrst_count", search_count, exp_sc);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        rv_seen = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (result_valid) rv_seen++;
        end
        check("midrst_no_result", rv_seen, 0);
        check("midrst_qready_after", query_ready, 1);
        $display("query midscan_reset: result cycles after release=%0d", rv_seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
